// File: rtl/cmd_dispatcher_if.sv
// Host-side command intake and GPU-side issue/done handshake for cmd_dispatcher.
// DEPTH must match the dispatcher's DEPTH so that level has the right width.
interface cmd_dispatcher_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [127:0]  in_data;
  logic          in_ready;
  logic          cmd_valid;
  logic [127:0]  cmd_data;
  logic          cmd_ready;
  logic          gpu_done;
  logic          flush;
  logic [LW-1:0] level;
  logic [7:0]    drop_count;
  logic          timeout_err;
  logic          idle;

  modport master (
    output in_valid, in_data, cmd_ready, gpu_done, flush,
    input  in_ready, cmd_valid, cmd_data, level, drop_count, timeout_err, idle
  );

  modport slave (
    input  in_valid, in_data, cmd_ready, gpu_done, flush,
    output in_ready, cmd_valid, cmd_data, level, drop_count, timeout_err, idle
  );
endinterface

// File: rtl/cmd_dispatcher.sv
// Queues host drawing commands and issues them one at a time to the GPU core,
// waiting for gpu_done (or a timeout) before issuing the next one.
module cmd_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input logic             clk,
  input logic             rst_n,
  cmd_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [127:0]  cmd_data_q, cmd_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    drop_q, drop_d;
  logic          terr_q, terr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [127:0]  mem_q [DEPTH];

  logic in_ready_w, accept, bad_op, push, pop;

  // rst_n gates in_ready so nothing is accepted while reset is held
  assign in_ready_w = rst_n && (level_q < LW'(DEPTH)) && !bus.flush;
  assign accept     = bus.in_valid && in_ready_w;
  assign bad_op     = bus.in_data[127:124] > 4'd2;
  assign push       = accept && !bad_op;
  assign pop        = (state_q == S_ISSUE) && bus.cmd_ready && !bus.flush;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    drop_d      = drop_q;
    terr_d      = terr_q;
    timer_d     = timer_q;

    if (accept && bad_op && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          cmd_data_d  = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // gpu_done wins over a timeout landing on the same cycle
        if (bus.gpu_done) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d     = S_IDLE;
      cmd_valid_d = 1'b0;
      terr_d      = 1'b0;
      timer_d     = '0;
      level_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      drop_q      <= '0;
      terr_q      <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      drop_q      <= drop_d;
      terr_q      <= terr_d;
      timer_q     <= timer_d;
    end
  end

  // Queue storage holds only data, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.level       = level_q;
  assign bus.drop_count  = drop_q;
  assign bus.timeout_err = terr_q;
  assign bus.idle        = (state_q == S_IDLE) && (level_q == '0);
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: directed scenarios followed by random
// traffic, all checked against a queue-based model of the dispatcher.
module tb_cmd_dispatcher;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_dispatcher_if #(.DEPTH(DEPTH)) bus ();
  cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands in arrival order, one outstanding flag
  logic [127:0] exp_q[$];
  bit m_out = 0;
  int m_wait = 0;
  bit m_err = 0;
  int m_drop = 0;
  int stall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_out = 0; m_wait = 0; m_err = 0; m_drop = 0; stall = 0;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_idle", bus.idle, 1);
      check("rst_cmd_valid", bus.cmd_valid, 0);
      check("rst_level", bus.level, 0);
      check("rst_drop", bus.drop_count, 0);
      check("rst_terr", bus.timeout_err, 0);
    end else begin
      check("level", bus.level, exp_q.size());
      check("drop_count", bus.drop_count, m_drop);
      check("timeout_err", bus.timeout_err, m_err);
      check("idle", bus.idle, (exp_q.size() == 0 && !m_out));
      check("in_ready", bus.in_ready, (exp_q.size() < DEPTH && !bus.flush));
      if (bus.cmd_valid) check("single_outstanding", (m_out || exp_q.size() == 0), 0);
      if (!m_out && exp_q.size() > 0 && !bus.cmd_valid) stall++; else stall = 0;
      check("issue_latency", (stall > 2), 0);
      if (bus.flush) begin
        exp_q.delete();
        m_out = 0; m_wait = 0; m_err = 0; stall = 0;
      end else begin
        if (m_out) begin
          if (bus.gpu_done) m_out = 0;
          else if (m_wait == TIMEOUT - 1) begin m_err = 1; m_out = 0; end
          else m_wait++;
        end else if (bus.cmd_valid && bus.cmd_ready) begin
          check("issue_nonempty", (exp_q.size() == 0), 0);
          if (exp_q.size() > 0) begin
            check("cmd_data", bus.cmd_data, exp_q[0]);
            void'(exp_q.pop_front());
            m_out = 1; m_wait = 0;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          if (bus.in_data[127:124] <= 4'd2) exp_q.push_back(bus.in_data);
          else if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  // GPU responder: 0 = follow force_done, 1 = pulse 5 cycles after each issue, 2 = random
  int done_mode = 0;
  bit force_done = 0;
  int done_cnt = 0;
  bit hs = 0;
  initial begin
    bus.gpu_done = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.cmd_valid && bus.cmd_ready && !bus.flush && rst_n;
      @(posedge clk);
      #2;
      bus.gpu_done = 1'b0;
      if (done_mode == 0) bus.gpu_done = force_done;
      else if (done_mode == 2) bus.gpu_done = ($urandom_range(0, 6) == 0);
      else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) bus.gpu_done = 1'b1;
        end
        if (hs) done_cnt = 5;
      end
    end
  end

  function automatic logic [127:0] rand_word(input bit valid_only);
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (valid_only || $urandom_range(0, 9) < 8) w[127:124] = 4'($urandom_range(0, 2));
    else w[127:124] = 4'($urandom_range(3, 15));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid with w until accepted; leaves in_valid high on return
  task automatic push_word(input logic [127:0] w);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    check("push_accept", acc, 1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int n = 0; n < bound && !ok; n++) begin
      @(negedge clk);
      ok = bus.idle;
    end
    check("drain_to_idle", ok, 1);
    tick();
  endtask

  task automatic abandon(input bit in_wait);
    bit ok = 0;
    done_mode = 0;
    bus.cmd_ready = in_wait;
    push_word(rand_word(1));
    bus.in_valid = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.cmd_valid;
    end
    check("reach_issue", ok, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_cmd_valid", bus.cmd_valid, 0);
    check("async_idle", bus.idle, 1);
    check("async_in_ready", bus.in_ready, 0);
    bus.cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_done = 1'b1;
    tick();
    tick();
    force_done = 1'b0;
    @(negedge clk);
    check("late_done_idle", bus.idle, 1);
    check("late_done_no_issue", bus.cmd_valid, 0);
    tick();
  endtask

  initial begin
    logic [127:0] w40;
    logic [7:0] saved;
    bit ok;
    int cnt;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.cmd_ready = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_data", bus.cmd_data, 0);
    check("post_rst_in_ready", bus.in_ready, 1);
    tick();

    // Single rect command: latency, data and done handling
    w40 = {4'd2, 8'd20, 8'd20, 8'd30, 8'd100, 16'd0, 1'b1, 24'hFF00FF, 24'd0, 27'd0};
    push_word(w40);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", bus.cmd_valid, 0);
    @(negedge clk);
    check("lat_cycle2", bus.cmd_valid, 1);
    check("issue_data", bus.cmd_data, w40);
    tick();
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    @(negedge clk);
    check("wait_cmd_valid", bus.cmd_valid, 0);
    check("wait_not_idle", bus.idle, 0);
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    @(negedge clk);
    check("done_idle", bus.idle, 1);
    tick();

    // Fill the queue, then stream with automatic gpu_done
    done_mode = 1;
    for (int i = 0; i < 4; i++) push_word(rand_word(1));
    bus.in_data = rand_word(1);
    @(negedge clk);
    check("full_level", bus.level, 4);
    check("full_in_ready", bus.in_ready, 0);
    tick();
    bus.cmd_ready = 1'b1;
    push_word(bus.in_data);
    bus.in_valid = 1'b0;
    wait_idle(300);

    // Invalid opcode dropped, following line issued
    push_word({4'd7, 124'(rand_word(0))});
    push_word({4'd0, 124'(rand_word(0))});
    bus.in_valid = 1'b0;
    wait_idle(100);
    check("drop_one", bus.drop_count, 1);

    // Timeout without gpu_done; second command still issues
    done_mode = 0;
    push_word(rand_word(1));
    push_word(rand_word(1));
    bus.in_valid = 1'b0;
    ok = 0; cnt = -1;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (cnt < 0 && bus.cmd_valid && bus.cmd_ready) cnt = 0;
      else if (cnt >= 0) begin
        cnt++;
        ok = bus.timeout_err;
      end
    end
    check("timeout_seen", ok, 1);
    check("timeout_cycle", cnt, 17);
    tick();
    wait_idle(100);
    check("timeout_sticky", bus.timeout_err, 1);

    // Flush with gpu_done and in_valid while commands are queued behind WAIT_DONE
    push_word(rand_word(1));
    bus.in_valid = 1'b0;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.cmd_valid;
    end
    check("flush_setup_issue", ok, 1);
    tick();
    for (int i = 0; i < 3; i++) push_word(rand_word(1));
    saved = bus.drop_count;
    bus.in_data = rand_word(1);
    bus.flush = 1'b1;
    force_done = 1'b1;
    tick();
    bus.flush = 1'b0;
    force_done = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_level", bus.level, 0);
    check("flush_idle", bus.idle, 1);
    check("flush_drop_kept", bus.drop_count, saved);
    check("flush_terr_clear", bus.timeout_err, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_issue", bus.cmd_valid, 0);
    end
    tick();

    // Asynchronous reset mid-ISSUE and mid-WAIT_DONE
    abandon(1'b0);
    abandon(1'b1);

    // Random traffic
    done_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_data   = rand_word(0);
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 99) == 0);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.cmd_ready = 1'b1;
    wait_idle(400);

    // drop_count saturation
    done_mode = 0;
    for (int i = 0; i < 300; i++) push_word({4'hF, 124'(rand_word(0))});
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("drop_saturate", bus.drop_count, 255);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
